conv_window_scheduler: RTL

- Sequences one frame of a single-channel feature map from a synchronous pixel memory into the 3x3 window generator stage.
- Issues raster-order read addresses and drives the generator's pixel_valid strobe.
- Tracks the row and column of each emitted pixel and flags the pixels that complete a full 3x3 window.
- Applies downstream backpressure and reports frame completion; sits between the feature-map buffer and the window generator / conv engine.

---
 rtl/conv_window_scheduler_if.sv | 30 +++
 rtl/conv_window_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler_if.sv
// Handshake and pixel-emission bundle between the frame scheduler, the pixel
// memory and the window generator. The scheduler side uses the master modport.
interface conv_window_scheduler_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  start;
  logic                  conv_ready;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  pixel_valid;
  logic [CNT_WIDTH-1:0]  row_idx;
  logic [CNT_WIDTH-1:0]  col_idx;
  logic                  win_valid;
  logic [ADDR_WIDTH-1:0] win_count;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  start, conv_ready,
    output mem_rd_en, mem_addr, pixel_valid, row_idx, col_idx,
           win_valid, win_count, busy, frame_done
  );

  modport slave (
    output start, conv_ready,
    input  mem_rd_en, mem_addr, pixel_valid, row_idx, col_idx,
           win_valid, win_count, busy, frame_done
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Raster-order frame fetch sequencer for a 3x3 window generator. Reads one
// square frame from a 1-cycle-latency pixel memory, presents each pixel with
// its row/column one cycle after the read, flags pixels that complete a full
// 3x3 window and counts them. Reads stall while conv_ready is low.
module conv_window_scheduler #(
  parameter int IMAGE_SIZE = 222,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst,
  conv_window_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_SIZE * IMAGE_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_IDX  = CNT_WIDTH'(IMAGE_SIZE - 1);

  state_t                state_r;
  state_t                state_s;
  logic                  rd_en_s;
  logic                  busy_s;
  logic                  done_s;
  logic                  start_ok_s;

  // Read pointer plus the row/column of the pixel it addresses.
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [CNT_WIDTH-1:0]  rd_row_r;
  logic [CNT_WIDTH-1:0]  rd_col_r;

  // Emission-side registers, aligned with the returning memory data.
  logic                  pixel_valid_r;
  logic                  win_valid_r;
  logic [CNT_WIDTH-1:0]  row_idx_r;
  logic [CNT_WIDTH-1:0]  col_idx_r;
  logic [ADDR_WIDTH-1:0] win_count_r;
  logic                  win_hit_s;

  // Pixel completes a window once two full rows and columns precede it.
  assign win_hit_s = (rd_row_r >= CNT_WIDTH'(2)) && (rd_col_r >= CNT_WIDTH'(2));

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_s    = state_r;
    rd_en_s    = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    start_ok_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s    = S_FETCH;
          start_ok_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        busy_s  = 1'b1;
        rd_en_s = bus.conv_ready;
        if (bus.conv_ready && (ptr_r == LAST_ADDR)) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DRAIN: begin
        busy_s  = 1'b1;
        state_s = S_DONE;
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Read pointer and its row/column; parks on the last address so it never overruns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r    <= '0;
      rd_row_r <= '0;
      rd_col_r <= '0;
    end else if (start_ok_s) begin
      ptr_r    <= '0;
      rd_row_r <= '0;
      rd_col_r <= '0;
    end else if (rd_en_s && (ptr_r != LAST_ADDR)) begin
      ptr_r <= ptr_r + ADDR_WIDTH'(1);
      if (rd_col_r == LAST_IDX) begin
        rd_col_r <= '0;
        rd_row_r <= rd_row_r + CNT_WIDTH'(1);
      end else begin
        rd_col_r <= rd_col_r + CNT_WIDTH'(1);
      end
    end
  end

  // Emission path: mirrors each read one cycle later with its coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_valid_r <= 1'b0;
      win_valid_r   <= 1'b0;
      row_idx_r     <= '0;
      col_idx_r     <= '0;
      win_count_r   <= '0;
    end else begin
      pixel_valid_r <= rd_en_s;
      win_valid_r   <= rd_en_s && win_hit_s;
      if (start_ok_s) begin
        row_idx_r   <= '0;
        col_idx_r   <= '0;
        win_count_r <= '0;
      end else if (rd_en_s) begin
        row_idx_r <= rd_row_r;
        col_idx_r <= rd_col_r;
        if (win_hit_s) begin
          win_count_r <= win_count_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign bus.mem_rd_en   = rd_en_s;
  assign bus.mem_addr    = ptr_r;
  assign bus.busy        = busy_s;
  assign bus.frame_done  = done_s;
  assign bus.pixel_valid = pixel_valid_r;
  assign bus.win_valid   = win_valid_r;
  assign bus.row_idx     = row_idx_r;
  assign bus.col_idx     = col_idx_r;
  assign bus.win_count   = win_count_r;

endmodule
